// File: rtl/cnn_pkg.sv
// Shared fixed-point constants and types for the CNN datapath (signed Q8.8 pixels/weights).
package cnn_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 36;
  localparam int TAPS   = 9;

  localparam logic signed [DATA_W-1:0] Q88_MAX  = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] Q88_MIN  = 16'sh8000;
  localparam logic signed [ACC_W-1:0]  RND_HALF = 36'sd128;

  typedef logic signed [DATA_W-1:0] q88_t;
endpackage

// File: rtl/q88_round_sat.sv
// Combinational Q16.16-style accumulator to Q8.8: round half up, then clamp to the Q8.8 range.
module q88_round_sat
  import cnn_pkg::*;
(
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_q
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(Q88_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(Q88_MIN);

  logic signed [ACC_W-1:0] w_rnd;
  logic signed [ACC_W-1:0] w_shr;

  assign w_rnd = i_acc + RND_HALF;
  assign w_shr = w_rnd >>> FRAC_W;

  // Clamp the rounded value into the representable Q8.8 range
  always_comb begin
    if (w_shr > SAT_HI) begin
      o_q = Q88_MAX;
    end else if (w_shr < SAT_LO) begin
      o_q = Q88_MIN;
    end else begin
      o_q = w_shr[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/conv3x3_pe.sv
// Streaming 3x3 convolution PE: 3-stage multiply / row-sum / round-saturate pipeline,
// emitting valid-padding outputs only. Optional ReLU on the output via CONV_RELU_EN.
module conv3x3_pe #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9*DATA_W-1:0]   window_flat,
  input  logic                  win_valid,
  input  logic                  weight_we,
  input  logic [3:0]            weight_addr,
  input  logic [DATA_W-1:0]     weight_data,
  input  logic [DATA_W-1:0]     bias,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  frame_done
);
  import cnn_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  q88_t                   r_kernel [TAPS];
  logic [CW-1:0]          r_col;
  logic [RW-1:0]          r_row;
  logic                   w_accept;
  logic                   w_last;
  logic signed [PW-1:0]   w_prod [TAPS];
  logic signed [PW-1:0]   r_prod [TAPS];
  q88_t                   r_bias1;
  q88_t                   r_bias2;
  logic                   r_v1;
  logic                   r_last1;
  logic                   r_v2;
  logic                   r_last2;
  logic signed [SW-1:0]   r_rsum [3];
  logic signed [ACC_W-1:0] w_acc;
  q88_t                   w_sat;
  q88_t                   w_res;

  assign w_accept = win_valid && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
  assign w_last   = (r_row == ROW_LAST) && (r_col == COL_LAST);

  // Kernel register file; out-of-range tap addresses are dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) r_kernel[k] <= 16'sh0000;
    end else if (weight_we && (weight_addr < 4'd9)) begin
      r_kernel[weight_addr] <= weight_data;
    end
  end

  // Raster position of the window's bottom-right pixel
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_col <= {CW{1'b0}};
      r_row <= {RW{1'b0}};
    end else if (win_valid) begin
      if (r_col == COL_LAST) begin
        r_col <= {CW{1'b0}};
        r_row <= (r_row == ROW_LAST) ? {RW{1'b0}} : r_row + ROW_ONE;
      end else begin
        r_col <= r_col + COL_ONE;
      end
    end
  end

  // Tap products use the kernel as it stands before any same-edge write
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_prod[k] = PW'($signed(window_flat[k*DATA_W +: DATA_W])) * PW'(r_kernel[k]);
    end
  end

  // S1: products, bias and flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_bias1 <= 16'sh0000;
      for (int k = 0; k < TAPS; k++) r_prod[k] <= {PW{1'b0}};
    end else begin
      r_v1    <= w_accept;
      r_last1 <= w_accept && w_last;
      if (w_accept) begin
        r_bias1 <= bias;
        for (int k = 0; k < TAPS; k++) r_prod[k] <= w_prod[k];
      end
    end
  end

  // S2: one partial sum per kernel row
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_bias2 <= 16'sh0000;
      for (int r = 0; r < 3; r++) r_rsum[r] <= {SW{1'b0}};
    end else begin
      r_v2    <= r_v1;
      r_last2 <= r_last1;
      if (r_v1) begin
        r_bias2 <= r_bias1;
        for (int r = 0; r < 3; r++) begin
          r_rsum[r] <= SW'(r_prod[3*r]) + SW'(r_prod[3*r+1]) + SW'(r_prod[3*r+2]);
        end
      end
    end
  end

  // Bias is Q8.8 while products are Q16.16, hence the shift before adding
  assign w_acc = ACC_W'(r_rsum[0]) + ACC_W'(r_rsum[1]) + ACC_W'(r_rsum[2])
               + (ACC_W'(r_bias2) <<< FRAC_W);

  q88_round_sat u_round_sat (
    .i_acc (w_acc),
    .o_q   (w_sat)
  );

`ifdef CONV_RELU_EN
  assign w_res = w_sat[DATA_W-1] ? 16'sh0000 : w_sat;
`else
  assign w_res = w_sat;
`endif

  // S3: registered result; dout holds between valid outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout       <= {DATA_W{1'b0}};
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= r_v2;
      frame_done <= r_v2 && r_last2;
      if (r_v2) begin
        dout <= w_res;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_pe.sv
// Scoreboard bench for conv3x3_pe: arithmetic reference model feeds an expected-result queue,
// an independent monitor checks outputs. Build with CONV_RELU_EN to check the ReLU variant.
module tb_conv3x3_pe;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [9*DW-1:0] window_flat;
  logic            win_valid;
  logic            weight_we;
  logic [3:0]      weight_addr;
  logic [DW-1:0]   weight_data;
  logic [DW-1:0]   bias;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic            frame_done;

  conv3x3_pe #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .window_flat (window_flat),
    .win_valid   (win_valid),
    .weight_we   (weight_we),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .bias        (bias),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] val;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t               q[$];
  int                 n_checks = 0;
  int                 n_pass   = 0;
  int                 cyc      = 0;
  logic               rst_smp  = 1'b0;
  logic [15:0]        exp_hold = 16'h0000;
  logic signed [15:0] kmodel [9];
  logic [15:0]        img [H][W];
  logic [15:0]        zwin [9];
  logic [15:0]        kv [9];
  int                 pr = 0;
  int                 pc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_smp <= !reset;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: exact integer convolution, round half up, clamp (and optional ReLU)
  function automatic logic [15:0] ref_conv(input logic [15:0] win [9], input logic [15:0] b);
    longint s = 0;
    for (int k = 0; k < 9; k++) s += longint'($signed(win[k])) * longint'(kmodel[k]);
    s += longint'($signed(b)) * 256;
    s = (s + 128) >>> 8;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  // One input cycle; the expected result uses the kernel before this cycle's write
  task automatic step(input bit v, input logic [15:0] win [9], input logic [15:0] b,
                      input bit we, input logic [3:0] wa, input logic [15:0] wd);
    exp_t e;
    @(posedge clk); #1;
    win_valid = v;
    for (int k = 0; k < 9; k++) window_flat[k*16 +: 16] = win[k];
    bias        = b;
    weight_we   = we;
    weight_addr = wa;
    weight_data = wd;
    if (v) begin
      if (pr >= 2 && pc >= 2) begin
        e.val  = ref_conv(win, b);
        e.last = (pr == H-1) && (pc == W-1);
        e.cyc  = cyc + 3;
        q.push_back(e);
      end
      if (pc == W-1) begin
        pc = 0;
        pr = (pr == H-1) ? 0 : pr + 1;
      end else begin
        pc++;
      end
    end
    if (we && wa < 4'd9) kmodel[wa] = wd;
  endtask

  task automatic idle();
    step(1'b0, zwin, 16'h0000, 1'b0, 4'd0, 16'h0000);
  endtask

  task automatic load_kernel(input logic [15:0] wv [9]);
    for (int k = 0; k < 9; k++) step(1'b0, zwin, 16'h0000, 1'b1, 4'(k), wv[k]);
    step(1'b0, zwin, 16'h0000, 1'b1, 4'(9 + $urandom_range(0, 6)), 16'(32'h5A5A + $urandom_range(0, 255)));
  endtask

  task automatic fill_img(input logic [15:0] v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic ramp_img();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 16'((r*W + c + 1) * 256);
  endtask

  // gap_mode: 0 back-to-back, 1 alternate cycles, 2 random gaps
  task automatic send_frame(input int gap_mode, input bit rnd, input logic [15:0] b, input int nwin);
    logic [15:0] win [9];
    logic [15:0] bb;
    bit          we;
    logic [3:0]  wa;
    logic [15:0] wd;
    int          n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < nwin) begin
          for (int k = 0; k < 9; k++) begin
            int rr;
            int cc;
            rr = r - 2 + k / 3;
            cc = c - 2 + k % 3;
            win[k] = (rr >= 0 && cc >= 0) ? img[rr][cc] : 16'($urandom);
          end
          bb = rnd ? 16'($urandom) : b;
          we = rnd && ($urandom_range(0, 3) == 0);
          wa = 4'($urandom_range(0, 15));
          wd = 16'($urandom);
          step(1'b1, win, bb, we, wa, wd);
          n++;
          if (gap_mode == 1) idle();
          if (gap_mode == 2) repeat ($urandom_range(0, 2)) idle();
        end
      end
    end
  endtask

  // Drop expectations that cannot emerge before the reset is sampled
  task automatic do_reset(input int ncyc);
    exp_t e;
    @(posedge clk); #1;
    reset     = 1'b0;
    win_valid = 1'b0;
    weight_we = 1'b0;
    while (q.size() > 0 && q[$].cyc > cyc) e = q.pop_back();
    pr = 0;
    pc = 0;
    for (int k = 0; k < 9; k++) kmodel[k] = 16'sh0000;
    repeat (ncyc) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Monitor: compares every presented output with the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_smp) begin
      exp_hold = 16'h0000;
      check("reset_dout", dout, 0);
      check("reset_dout_valid", dout_valid, 0);
      check("reset_frame_done", frame_done, 0);
    end else if (dout_valid) begin
      if (q.size() == 0) begin
        check("spurious_dout_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("dout", $signed(dout), $signed(e.val));
        check("frame_done", frame_done, e.last);
        check("latency_cycle", cyc, e.cyc);
        exp_hold = e.val;
      end
    end else begin
      check("dout_hold", $signed(dout), $signed(exp_hold));
      check("frame_done_idle", frame_done, 0);
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check("missing_dout_valid", 0, 1);
      end
    end
  end

  initial begin
    reset       = 1'b0;
    win_valid   = 1'b0;
    weight_we   = 1'b0;
    weight_addr = 4'd0;
    weight_data = 16'h0000;
    bias        = 16'h0000;
    window_flat = {(9*DW){1'b0}};
    for (int k = 0; k < 9; k++) begin
      zwin[k]   = 16'h0000;
      kmodel[k] = 16'sh0000;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Ramp image, all-ones kernel: back-to-back then alternate-cycle windows
    for (int k = 0; k < 9; k++) kv[k] = 16'h0100;
    load_kernel(kv);
    ramp_img();
    send_frame(0, 1'b0, 16'h0000, 16);
    repeat (4) idle();
    send_frame(1, 1'b0, 16'h0000, 16);
    repeat (4) idle();

    // Centre tap -1.0 on a constant 5.0 image
    for (int k = 0; k < 9; k++) kv[k] = (k == 4) ? 16'hFF00 : 16'h0000;
    load_kernel(kv);
    fill_img(16'h0500);
    send_frame(0, 1'b0, 16'h0000, 16);

    // Positive and negative saturation
    for (int k = 0; k < 9; k++) kv[k] = 16'h7FFF;
    load_kernel(kv);
    fill_img(16'h7FFF);
    send_frame(0, 1'b0, 16'h0000, 16);
    for (int k = 0; k < 9; k++) kv[k] = 16'h8000;
    load_kernel(kv);
    send_frame(0, 1'b0, 16'h0000, 16);

    // Rounding of a half LSB, without and with bias
    for (int k = 0; k < 9; k++) kv[k] = (k == 0) ? 16'h0080 : 16'h0000;
    load_kernel(kv);
    fill_img(16'h0001);
    send_frame(0, 1'b0, 16'h0000, 16);
    send_frame(0, 1'b0, 16'h0100, 16);

    // Random kernels, pixels, biases, gaps and in-frame weight writes
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 9; k++) kv[k] = (f < 3) ? 16'($urandom_range(0, 1023) - 512) : 16'($urandom);
      load_kernel(kv);
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[r][c] = (f < 3) ? 16'($urandom_range(0, 4095) - 2048) : 16'($urandom);
      send_frame(2, 1'b1, 16'h0000, 16);
    end
    repeat (4) idle();

    // Reset with one in-image result in flight, then reload and replay the ramp frame
    for (int k = 0; k < 9; k++) kv[k] = 16'h0100;
    load_kernel(kv);
    ramp_img();
    send_frame(0, 1'b0, 16'h0000, 11);
    do_reset(2);
    load_kernel(kv);
    send_frame(0, 1'b0, 16'h0000, 16);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
